display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 160 ++++++++++++++++
 tb/tb_display_scan.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Four-digit multiplexed 7-segment scanner with double-buffered display data.
// New data is staged in a shadow register and only shown from a frame boundary.
//
// state   | meaning
// S_BLANK | first BLANK_CYC cycles of a slot, every line inactive
// S_ON    | remainder of the slot, digit IDX+1 lit if its enable bit is set
module display_scan #(
  parameter int DIV            = 50000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP,
  input  logic [3:0]  EN,
  input  logic        LOAD,
  output logic        SEG_a,
  output logic        SEG_b,
  output logic        SEG_c,
  output logic        SEG_d,
  output logic        SEG_e,
  output logic        SEG_f,
  output logic        SEG_g,
  output logic        SEG_h,
  output logic        SEG_1,
  output logic        SEG_2,
  output logic        SEG_3,
  output logic        SEG_4,
  output logic        PENDING,
  output logic        FRAME
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK_N  = PW'(BLANK_CYC);
  localparam logic [7:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]    DIG_OFF  = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic {S_BLANK, S_ON} slot_state_t;

  logic [PW-1:0] pre, pre_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          pre_wrap, boundary;
  slot_state_t   state_nxt;

  logic [15:0] sh_data, disp_data, disp_data_nxt;
  logic [3:0]  sh_dp, sh_en, disp_dp, disp_dp_nxt, disp_en, disp_en_nxt;
  logic        pending_q, pending_nxt, frame_q;

  logic [3:0] nib;
  logic       dp_bit, en_bit;
  logic [6:0] seg_raw;
  logic       dp_raw;
  logic [3:0] dig_raw;
  logic [7:0] seg_q;
  logic [3:0] dig_q;

  // Bit order {a,b,c,d,e,f,g}, active-high.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b1111110;
      4'h1:    hex7 = 7'b0110000;
      4'h2:    hex7 = 7'b1101101;
      4'h3:    hex7 = 7'b1111001;
      4'h4:    hex7 = 7'b0110011;
      4'h5:    hex7 = 7'b1011011;
      4'h6:    hex7 = 7'b1011111;
      4'h7:    hex7 = 7'b1110000;
      4'h8:    hex7 = 7'b1111111;
      4'h9:    hex7 = 7'b1111011;
      4'hA:    hex7 = 7'b1110111;
      4'hB:    hex7 = 7'b0011111;
      4'hC:    hex7 = 7'b1001110;
      4'hD:    hex7 = 7'b0111101;
      4'hE:    hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  // Outputs are decoded from next-state values so the registered lines line
  // up with the PRE/IDX value of the same cycle.
  always_comb begin
    pre_wrap      = (pre == PRE_LAST);
    pre_nxt       = pre_wrap ? '0 : pre + 1'b1;
    idx_nxt       = pre_wrap ? idx + 2'd1 : idx;
    boundary      = pre_wrap && (idx == 2'd3);
    disp_data_nxt = disp_data;
    disp_dp_nxt   = disp_dp;
    disp_en_nxt   = disp_en;
    if (boundary && pending_q) begin
      disp_data_nxt = sh_data;
      disp_dp_nxt   = sh_dp;
      disp_en_nxt   = sh_en;
    end
    pending_nxt = LOAD ? 1'b1 : (boundary ? 1'b0 : pending_q);
    state_nxt   = (pre_nxt < BLANK_N) ? S_BLANK : S_ON;

    nib    = disp_data_nxt[15:12];
    dp_bit = disp_dp_nxt[3];
    en_bit = disp_en_nxt[3];
    case (idx_nxt)
      2'd1: begin nib = disp_data_nxt[11:8]; dp_bit = disp_dp_nxt[2]; en_bit = disp_en_nxt[2]; end
      2'd2: begin nib = disp_data_nxt[7:4];  dp_bit = disp_dp_nxt[1]; en_bit = disp_en_nxt[1]; end
      2'd3: begin nib = disp_data_nxt[3:0];  dp_bit = disp_dp_nxt[0]; en_bit = disp_en_nxt[0]; end
      default: ;
    endcase

    seg_raw = '0;
    dp_raw  = 1'b0;
    dig_raw = '0;
    if (state_nxt == S_ON && en_bit) begin
      seg_raw          = hex7(nib);
      dp_raw           = dp_bit;
      dig_raw[idx_nxt] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pre       <= '0;
      idx       <= '0;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
      disp_en   <= '0;
      pending_q <= 1'b0;
      frame_q   <= 1'b0;
      seg_q     <= SEG_OFF;
      dig_q     <= DIG_OFF;
    end else begin
      pre       <= pre_nxt;
      idx       <= idx_nxt;
      disp_data <= disp_data_nxt;
      disp_dp   <= disp_dp_nxt;
      disp_en   <= disp_en_nxt;
      pending_q <= pending_nxt;
      frame_q   <= boundary;
      seg_q     <= {seg_raw, dp_raw} ^ SEG_OFF;
      dig_q     <= dig_raw ^ DIG_OFF;
      if (LOAD) begin
        sh_data <= DATA;
        sh_dp   <= DP;
        sh_en   <= EN;
      end
    end
  end

  assign {SEG_a, SEG_b, SEG_c, SEG_d, SEG_e, SEG_f, SEG_g, SEG_h} = seg_q;
  assign SEG_1   = dig_q[0];
  assign SEG_2   = dig_q[1];
  assign SEG_3   = dig_q[2];
  assign SEG_4   = dig_q[3];
  assign PENDING = pending_q;
  assign FRAME   = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: a frame-level model driven by an absolute cycle count
// predicts every output on every cycle, plus targeted scenario checks.
module tb_display_scan;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FLEN  = 4 * DIV;

  logic        CLK = 1'b0;
  logic        RST, LOAD;
  logic [15:0] DATA;
  logic [3:0]  DP, EN;
  logic SEG_a, SEG_b, SEG_c, SEG_d, SEG_e, SEG_f, SEG_g, SEG_h;
  logic SEG_1, SEG_2, SEG_3, SEG_4, PENDING, FRAME;

  always #5 CLK = ~CLK;

  display_scan #(.DIV(DIV), .BLANK_CYC(BLANK), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .DP(DP), .EN(EN), .LOAD(LOAD),
    .SEG_a(SEG_a), .SEG_b(SEG_b), .SEG_c(SEG_c), .SEG_d(SEG_d), .SEG_e(SEG_e),
    .SEG_f(SEG_f), .SEG_g(SEG_g), .SEG_h(SEG_h),
    .SEG_1(SEG_1), .SEG_2(SEG_2), .SEG_3(SEG_3), .SEG_4(SEG_4),
    .PENDING(PENDING), .FRAME(FRAME)
  );

  string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  int vectors = 0, miscompares = 0;
  int t = 0;
  logic [15:0] m_sh_data = '0, m_data = '0;
  logic [3:0]  m_sh_dp = '0, m_dp = '0, m_sh_en = '0, m_en = '0;
  bit          m_pend = 0, m_frame = 0;

  function automatic logic [6:0] seg_of(input string s);
    logic [6:0] r;
    int pos;
    r = '0;
    for (int k = 0; k < s.len(); k++) begin
      pos = int'(s[k]) - 97;
      r[6 - pos] = 1'b1;
    end
    return r;
  endfunction

  // {a..g, h, SEG_1..SEG_4, PENDING, FRAME} at the pins, active-low lines.
  function automatic logic [13:0] expected();
    int p, i;
    logic [3:0] nib, dig;
    logic [6:0] segs;
    logic h;
    p = t % DIV;
    i = (t / DIV) % 4;
    nib = m_data[4*(3-i) +: 4];
    segs = '0; h = 1'b0; dig = '0;
    if (p >= BLANK && m_en[3-i]) begin
      segs = seg_of(glyph[nib]);
      h    = m_dp[3-i];
      dig  = 4'b1000 >> i;
    end
    return {~segs, ~h, ~dig, m_pend, m_frame};
  endfunction

  function automatic logic [13:0] observed();
    return {SEG_a, SEG_b, SEG_c, SEG_d, SEG_e, SEG_f, SEG_g, SEG_h,
            SEG_1, SEG_2, SEG_3, SEG_4, PENDING, FRAME};
  endfunction

  // Advance one clock and update the model with what the DUT sampled.
  task automatic tick();
    bit bnd;
    @(posedge CLK);
    if (RST) begin
      t = 0; m_sh_data = '0; m_data = '0; m_sh_dp = '0; m_dp = '0;
      m_sh_en = '0; m_en = '0; m_pend = 0; m_frame = 0;
    end else begin
      bnd = (t % FLEN) == FLEN - 1;
      if (bnd && m_pend) begin
        m_data = m_sh_data; m_dp = m_sh_dp; m_en = m_sh_en; m_pend = 0;
      end
      if (LOAD) begin
        m_sh_data = DATA; m_sh_dp = DP; m_sh_en = EN; m_pend = 1;
      end
      m_frame = bnd;
      t++;
    end
    #1;
  endtask

  task automatic drive(input bit ld, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
    LOAD = ld; DATA = d; DP = dp; EN = en;
  endtask

  task automatic test_reset();
    int nf, f1, f2;
    nf = 0; f1 = -1; f2 = -1;
    RST = 1'b1; drive(0, 16'h0, 4'h0, 4'h0);
    repeat (3) begin
      tick();
      vectors++;
      if (observed() !== 14'b11111111111100) begin
        miscompares++;
        $display("FAIL reset_hold t=%0d got %b want %b", t, observed(), 14'b11111111111100);
      end
    end
    RST = 1'b0;
    repeat (70) begin
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL idle t=%0d got %b want %b", t, observed(), expected());
      end
      if (FRAME === 1'b1) begin
        nf++;
        if (nf == 1) f1 = t; else if (nf == 2) f2 = t;
      end
    end
    vectors++;
    if (nf != 2 || f1 != 32 || f2 != 64) begin
      miscompares++;
      $display("FAIL frame_timing got n=%0d at %0d,%0d want n=2 at 32,64", nf, f1, f2);
    end
  endtask

  task automatic test_load_1234();
    int start, seg1_on, dp_on;
    seg1_on = 0; dp_on = 0;
    drive(1, 16'h1234, 4'b0001, 4'hF);
    tick();
    drive(0, 16'hFFFF, 4'hF, 4'h0);
    vectors++;
    if (PENDING !== 1'b1) begin
      miscompares++;
      $display("FAIL load_pending got %b want 1", PENDING);
    end
    start = (t / FLEN + 1) * FLEN;
    while (t < start + FLEN) begin
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL load_1234 t=%0d got %b want %b", t, observed(), expected());
      end
      if (t >= start && SEG_1 === 1'b0) seg1_on++;
      if (t >= start && SEG_h === 1'b0 && SEG_4 === 1'b0) dp_on++;
    end
    vectors++;
    if (seg1_on != 6 || dp_on != 6) begin
      miscompares++;
      $display("FAIL digit_on_time got seg1=%0d dp4=%0d want 6,6", seg1_on, dp_on);
    end
  endtask

  task automatic test_last_wins();
    int seen_a;
    logic [6:0] pat_a;
    seen_a = 0;
    pat_a = ~seg_of(glyph[10]);
    while (t % FLEN != 2) tick();
    drive(1, 16'hAAAA, 4'h0, 4'hF); tick();
    drive(0, 16'h0, 4'h0, 4'h0);
    while (t % FLEN != 10) tick();
    drive(1, 16'h5555, 4'h0, 4'hF); tick();
    drive(0, 16'h0, 4'h0, 4'h0);
    repeat (2 * FLEN + 10) begin
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL last_wins t=%0d got %b want %b", t, observed(), expected());
      end
      if ({SEG_a, SEG_b, SEG_c, SEG_d, SEG_e, SEG_f, SEG_g} === pat_a &&
          {SEG_1, SEG_2, SEG_3, SEG_4} !== 4'hF) seen_a++;
    end
    vectors++;
    if (seen_a != 0) begin
      miscompares++;
      $display("FAIL aaaa_shown got %0d cycles want 0", seen_a);
    end
  endtask

  task automatic test_back_to_back();
    while (t % FLEN != 5) tick();
    drive(1, 16'hC0DE, 4'b0100, 4'hF); tick();
    drive(0, 16'h0, 4'h0, 4'h0);
    while (t % FLEN != FLEN - 1) tick();
    drive(1, 16'h9876, 4'b0010, 4'hF); tick();
    drive(0, 16'h0, 4'h0, 4'h0);
    vectors++;
    if (PENDING !== 1'b1 || FRAME !== 1'b1) begin
      miscompares++;
      $display("FAIL boundary_load got pend=%b frame=%b want 1,1", PENDING, FRAME);
    end
    repeat (2 * FLEN) begin
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL boundary_seq t=%0d got %b want %b", t, observed(), expected());
      end
      tick();
    end
    vectors++;
    if (PENDING !== 1'b0) begin
      miscompares++;
      $display("FAIL boundary_clear got %b want 0", PENDING);
    end
  endtask

  task automatic test_enable_mask();
    int start, n1, n3, nbad;
    n1 = 0; n3 = 0; nbad = 0;
    drive(1, 16'h8888, 4'hF, 4'b1010); tick();
    drive(0, 16'h0, 4'h0, 4'h0);
    start = (t / FLEN + 1) * FLEN;
    while (t < start + 2 * FLEN) begin
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL enable_mask t=%0d got %b want %b", t, observed(), expected());
      end
      if (t >= start) begin
        if (SEG_1 === 1'b0) n1++;
        if (SEG_3 === 1'b0) n3++;
        if (SEG_2 !== 1'b1 || SEG_4 !== 1'b1) nbad++;
      end
    end
    vectors++;
    if (n1 != 12 || n3 != 12 || nbad != 0) begin
      miscompares++;
      $display("FAIL enable_count got d1=%0d d3=%0d off=%0d want 12,12,0", n1, n3, nbad);
    end
  endtask

  task automatic test_reset_mid();
    int lit;
    lit = 0;
    while (t % FLEN != 17) tick();
    drive(1, 16'hFFFF, 4'hF, 4'hF); tick();
    drive(0, 16'h0, 4'h0, 4'h0);
    tick(); tick();
    RST = 1'b1; tick(); RST = 1'b0;
    vectors++;
    if (observed() !== 14'b11111111111100) begin
      miscompares++;
      $display("FAIL reset_mid got %b want %b", observed(), 14'b11111111111100);
    end
    repeat (2 * FLEN + 6) begin
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL post_reset t=%0d got %b want %b", t, observed(), expected());
      end
      if ({SEG_1, SEG_2, SEG_3, SEG_4} !== 4'hF) lit++;
    end
    vectors++;
    if (lit != 0) begin
      miscompares++;
      $display("FAIL post_reset_blank got %0d lit cycles want 0", lit);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      RST = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 11) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
      tick();
      vectors++;
      if (observed() !== expected()) begin
        miscompares++;
        $display("FAIL random t=%0d got %b want %b", t, observed(), expected());
      end
    end
    RST = 1'b0;
    drive(0, 16'h0, 4'h0, 4'h0);
  endtask

  initial begin
    RST = 1'b1; LOAD = 1'b0; DATA = '0; DP = '0; EN = '0;
    test_reset();
    test_load_1234();
    test_last_wins();
    test_back_to_back();
    test_enable_mask();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
